// File: rtl/mmio_bus_fabric_pkg.sv
// Shared FSM state type, error data word and core memory-map constants for the MMIO fabric.
// The region_mask helper turns an inclusive [base, end] window into a compare mask.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] RAM_END      = 32'h0FFF_FFFF;
  localparam logic [31:0] PROG_BASE    = 32'h1000_0000;
  localparam logic [31:0] PROG_END     = 32'h1000_FFFF;
  localparam logic [31:0] SCREEN_BASE  = 32'h2000_0000;
  localparam logic [31:0] SCREEN_END   = 32'h2000_3FFF;
  localparam logic [31:0] FLASH_BASE   = 32'h3000_0000;
  localparam logic [31:0] FLASH_END    = 32'h3000_00FF;
  localparam logic [31:0] UART_BASE    = 32'h4000_0000;
  localparam logic [31:0] UART_END     = 32'h4000_00FF;
  localparam logic [31:0] BUTTON_BASE  = 32'h5000_0000;
  localparam logic [31:0] BUTTON_END   = 32'h5000_0003;
  localparam logic [31:0] COUNTER_BASE = 32'h6000_0000;
  localparam logic [31:0] COUNTER_END  = 32'h6000_000F;

  // Only valid for power-of-two sized, size-aligned windows.
  function automatic logic [31:0] region_mask(input logic [31:0] base_addr,
                                              input logic [31:0] end_addr);
    return ~(end_addr - base_addr);
  endfunction

endpackage

// File: rtl/mmio_bus_fabric_region_decode.sv
// Combinational priority address decoder: lowest-index matching region wins.
// hit_o is low when no region matches; the caller substitutes its default slave.
module mmio_region_decode
  import mmio_bus_pkg::*;
#(
  parameter int                            NUM_SLAVES  = 8,
  parameter int                            ADDR_W      = 32,
  parameter int                            SEL_W       = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              hit_o
);

  logic [NUM_SLAVES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = ((addr_i & REGION_MASK[gi*ADDR_W +: ADDR_W])
                          == REGION_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_o = SEL_W'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Registered MMIO bus fabric: decode, single-slave strobe, wait for ready, one-cycle done pulse.
// Define MMIO_BUS_TIMEOUT_EN to return a bus error after TIMEOUT_CYCLES instead of waiting forever.
module mmio_bus_fabric
  import mmio_bus_pkg::*;
#(
  parameter int                            NUM_SLAVES     = 8,
  parameter int                            ADDR_W         = 32,
  parameter int                            DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_MASK    = '0,
  parameter int                            DEFAULT_SLAVE  = NUM_SLAVES - 1,
  parameter int                            TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic                         m_ren,
  input  logic                         m_wen,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_ren,
  output logic [NUM_SLAVES-1:0]        s_wen,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SEL_W-1:0]    dec_sel;
  logic                dec_hit;
  logic                sel_ready;
  logic                access_rd;
  logic                access_wr;
  logic [DATA_W-1:0]   slv_rdata [NUM_SLAVES];

`ifdef MMIO_BUS_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
`endif

  mmio_region_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_W      (ADDR_W),
    .SEL_W       (SEL_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr_i (m_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // Strobes come only from registered state so they cannot glitch across slaves.
  assign access_rd = (state_q == ST_ACCESS) && !wr_q;
  assign access_wr = (state_q == ST_ACCESS) &&  wr_q;
  assign sel_ready = s_ready[sel_q];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign slv_rdata[gi] = s_rdata[gi*DATA_W +: DATA_W];
      assign s_ren[gi]     = access_rd && (sel_q == SEL_W'(gi));
      assign s_wen[gi]     = access_wr && (sel_q == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef MMIO_BUS_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_ren || m_wen) begin
          sel_d   = dec_hit ? dec_sel : SEL_W'(DEFAULT_SLAVE);
          wr_d    = m_wen;
          state_d = ST_ACCESS;
`ifdef MMIO_BUS_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_ACCESS: begin
        // A ready arriving on the expiry cycle still completes normally.
        if (sel_ready) begin
          rdata_d = wr_q ? '0 : slv_rdata[sel_q];
          state_d = ST_DONE;
`ifdef MMIO_BUS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef MMIO_BUS_TIMEOUT_EN
        else if (tmo_hit) begin
          rdata_d = DATA_W'(ERR_RDATA);
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_W'(DEFAULT_SLAVE);
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MMIO_BUS_TIMEOUT_EN
      err_q   <= 1'b0;
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef MMIO_BUS_TIMEOUT_EN
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign m_ready = (state_q == ST_DONE);
  assign m_rdata = rdata_q;
`ifdef MMIO_BUS_TIMEOUT_EN
  assign m_err   = err_q;
`else
  assign m_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed cases plus randomized accesses against a
// timeline model (strobe window, done cycle, held read data). Handles MMIO_BUS_TIMEOUT_EN builds.
module tb_mmio_bus_fabric;

  localparam int NS  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DEF = 7;
  localparam int TMO = 4;
  localparam int BIG = 1 << 30;

  // Region tables, index 0 first: PROG, UART, SCREEN, IO-wide, FLASH, BUTTON, COUNTER, RAM.
  localparam logic [31:0] MB [NS] = '{32'h1000_0000, 32'h4000_0000, 32'h2000_0000, 32'h4000_0000,
                                      32'h3000_0000, 32'h5000_0000, 32'h6000_0000, 32'h0000_0000};
  localparam logic [31:0] MM [NS] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_C000, 32'hFFFF_0000,
                                      32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hF000_0000};
  localparam logic [NS*AW-1:0] RB = {32'h0000_0000, 32'h6000_0000, 32'h5000_0000, 32'h3000_0000,
                                     32'h4000_0000, 32'h2000_0000, 32'h4000_0000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] RM = {32'hF000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FF00,
                                     32'hFFFF_0000, 32'hFFFF_C000, 32'hFFFF_FF00, 32'hFFFF_0000};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     m_addr;
  logic              m_ren, m_wen;
  logic              m_ready;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_ren, s_wen;
  logic [NS*DW-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;

  mmio_bus_fabric #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_BASE(RB), .REGION_MASK(RM),
    .DEFAULT_SLAVE(DEF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err), .s_ren(s_ren), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: current transaction timeline and the read data/error the master should see.
  int          exp_sel = DEF, exp_lo = -10, exp_hi = -10, exp_done = -1, clr_cyc = -1;
  int          rdy_cyc = BIG;
  bit          exp_wr = 1'b0;
  logic [31:0] exp_txn_rdata = '0, hold_rdata = '0;
  bit          exp_txn_err = 1'b0, hold_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & MM[i]) == MB[i]) return i;
    return DEF;
  endfunction

  // Slave side: selected slave becomes ready on its scheduled cycle, others toggle randomly.
  always @(posedge clk) begin
    #2;
    s_ready = NS'($urandom);
    s_ready[exp_sel] = (cyc >= rdy_cyc);
  end

  always @(negedge clk) begin : cmp
    logic [NS-1:0] oh, er, ew;
    if (chk_en) begin
      oh = '0;
      if (cyc >= exp_lo && cyc <= exp_hi) oh[exp_sel] = 1'b1;
      er = exp_wr ? '0 : oh;
      ew = exp_wr ? oh : '0;
      if (cyc == exp_done) begin
        hold_rdata = exp_txn_rdata;
        hold_err   = exp_txn_err;
      end
      if (cyc == clr_cyc) begin
        hold_rdata = '0;
        hold_err   = 1'b0;
      end
      chk("s_ren", 64'(s_ren), 64'(er));
      chk("s_wen", 64'(s_wen), 64'(ew));
      chk("m_ready", 64'(m_ready), 64'(cyc == exp_done));
      chk("m_rdata", 64'(m_rdata), 64'(hold_rdata));
      chk("m_err", 64'(m_err), 64'(hold_err));
    end
  end

  // Present a request in the current (idle) cycle and schedule its expected timeline.
  task automatic start_txn(input logic [31:0] addr, input bit rd, input bit wr, input int d,
                           input bit never, input bit use_fd, input logic [31:0] fd, output int k);
    int sel, lat;
    bit err;
    logic [31:0] sd;
    k = cyc;
    for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
    sel = model_sel(addr);
    if (use_fd) s_rdata[sel*DW +: DW] = fd;
    sd = s_rdata[sel*DW +: DW];
    m_addr = addr;
    m_ren  = rd;
    m_wen  = wr;
    err    = 1'b0;
`ifdef MMIO_BUS_TIMEOUT_EN
    if (never || d > TMO) begin
      lat = TMO + 1;
      err = 1'b1;
    end else lat = d + 1;
`else
    lat = never ? BIG : d + 1;
`endif
    exp_sel       = sel;
    exp_wr        = wr;
    exp_lo        = k + 1;
    exp_hi        = k + lat;
    exp_done      = (lat == BIG) ? -1 : k + lat + 1;
    exp_txn_err   = err;
    exp_txn_rdata = err ? 32'hDEAD_BEEF : (wr ? 32'h0 : sd);
    rdy_cyc       = never ? BIG : k + 1 + d;
  endtask

  task automatic wait_done(input int budget, output int rc);
    bit got = 1'b0;
    rc = -1;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (m_ready === 1'b1) begin
        got = 1'b1;
        rc  = cyc;
      end
    end
    chk("done_within_budget", 64'(got), 64'd1);
    @(posedge clk); #1;
    m_ren   = 1'b0;
    m_wen   = 1'b0;
    rdy_cyc = BIG;
  endtask

  task automatic directed(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                          input int d, input bit never, input logic [31:0] fd,
                          input logic [7:0] x_ren, input logic [7:0] x_wen, input int x_lat,
                          input logic [31:0] x_rdata, input bit x_err);
    int k, rc;
    start_txn(addr, rd, wr, d, never, 1'b1, fd, k);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_ren"}, 64'(s_ren), 64'(x_ren));
    chk({name, "_wen"}, 64'(s_wen), 64'(x_wen));
    wait_done(x_lat + 4, rc);
    chk({name, "_lat"}, 64'(rc - k), 64'(x_lat));
    chk({name, "_rdata"}, 64'(m_rdata), 64'(x_rdata));
    chk({name, "_err"}, 64'(m_err), 64'(x_err));
    $display("txn %s addr=%08h lat=%0d rdata=%08h err=%0b", name, addr, rc - k, m_rdata, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int k, r, rc, slot, d, g, ops;
    logic [31:0] a;
    rst_n = 1'b0; m_addr = '0; m_ren = 1'b0; m_wen = 1'b0; s_rdata = '0; s_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(m_ready), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_strobes", 64'(s_ren | s_wen), 64'd0);
    @(posedge clk); #1;

    directed("ram_read",  32'h0000_1234, 1, 0, 0, 0, 32'h1234_5678, 8'h80, 8'h00, 2, 32'h1234_5678, 0);
    directed("uart_wr",   32'h4000_0004, 0, 1, 3, 0, 32'h5555_AAAA, 8'h00, 8'h02, 5, 32'h0, 0);
    directed("unmapped",  32'hF000_0000, 1, 0, 1, 0, 32'hCAFE_0001, 8'h80, 8'h00, 3, 32'hCAFE_0001, 0);
    directed("overlap",   32'h4000_0000, 1, 0, 0, 0, 32'h0BAD_F00D, 8'h02, 8'h00, 2, 32'h0BAD_F00D, 0);
    directed("io_wide",   32'h4000_1000, 1, 0, 2, 0, 32'h3333_0003, 8'h08, 8'h00, 4, 32'h3333_0003, 0);
    directed("rd_and_wr", 32'h1000_0000, 1, 1, 0, 0, 32'h7777_7777, 8'h00, 8'h01, 2, 32'h0, 0);
`ifdef MMIO_BUS_TIMEOUT_EN
    directed("timeout",   32'h3000_0010, 1, 0, 0, 1, 32'h1111_1111, 8'h10, 8'h00, TMO + 2, 32'hDEAD_BEEF, 1);
    directed("tmo_edge",  32'h3000_0010, 1, 0, TMO, 0, 32'hA5A5_0001, 8'h10, 8'h00, TMO + 2, 32'hA5A5_0001, 0);
`endif

    // Slave never ready: either times out (checked above) or hangs in ACCESS until reset.
    start_txn(32'h2000_0040, 1, 0, 0, 1, 1'b0, 32'h0, k);
`ifdef MMIO_BUS_TIMEOUT_EN
    repeat (3) begin @(posedge clk); #1; end
`else
    repeat (20) begin @(posedge clk); #1; end
`endif
    r = cyc;
    rst_n = 1'b0; m_ren = 1'b0; m_wen = 1'b0;
    exp_hi = r; exp_done = -1; clr_cyc = r + 1; rdy_cyc = BIG;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", 64'(s_ren | s_wen), 64'd0);
    chk("midrst_ready", 64'(m_ready), 64'd0);
    $display("txn mid_access_reset at cyc %0d", r);
    @(posedge clk); #1;
    directed("post_rst", 32'h6000_0008, 1, 0, 1, 0, 32'h0C0F_FEE0, 8'h40, 8'h00, 3, 32'h0C0F_FEE0, 0);

    for (int t = 0; t < 150; t++) begin
      slot = $urandom_range(0, NS);
      if (slot == NS) a = $urandom;
      else a = MB[slot] | ($urandom & ~MM[slot]);
      ops = $urandom_range(1, 3);
`ifdef MMIO_BUS_TIMEOUT_EN
      d = $urandom_range(0, TMO + 2);
`else
      d = $urandom_range(0, 4);
`endif
      start_txn(a, ops[0], ops[1], d, 1'b0, 1'b0, 32'h0, k);
      wait_done(TMO + d + 6, rc);
      $display("txn rand%0d addr=%08h op=%0d d=%0d sel=%0d lat=%0d rdata=%08h err=%0b",
               t, a, ops, d, exp_sel, rc - k, m_rdata, m_err);
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
